axi_txn_regulator: RTL and testbench
====================================

// Module: axi_txn_regulator
// PURPOSE
//  Per-master AXI transaction regulator between NumPorts CVA6 hart ports and the CCU/interconnect.
//  Caps outstanding reads/writes per port, provides a per-port drain handshake and
//  counts R/B SLVERR/DECERR per port in hardware. Passive on payload; gates only AR/AW handshakes.
//  Successor of the simulation-only response check: synthesizable, parametrised over ports and depth.
// PARAMETERS
//  NumPorts    2   number of regulated master ports (one per hart)
//  MaxRdTxns   4   max outstanding read bursts per port (>=1)
//  MaxWrTxns   4   max outstanding write bursts per port (>=1)
//  ErrCntWidth 16  width of per-port saturating error counter
// PORTS
//  clk_i            in  1                       clock
//  rst_ni           in  1                       async reset, active low
//  ar_valid_i       in  NumPorts                AR valid from master
//  ar_ready_o       out NumPorts                AR ready to master (gated)
//  ar_valid_o       out NumPorts                AR valid to slave (gated)
//  ar_ready_i       in  NumPorts                AR ready from slave
//  aw_valid_i/aw_ready_o/aw_valid_o/aw_ready_i  as AR, write address channel
//  r_valid_i,r_ready_i,r_last_i in NumPorts     R handshake observed (not gated)
//  r_resp_i         in  NumPorts x 2            R response code
//  b_valid_i,b_ready_i in NumPorts              B handshake observed
//  b_resp_i         in  NumPorts x 2            B response code
//  drain_req_i      in  NumPorts                request to stop new txns and drain
//  drain_ack_o      out NumPorts                port drained (no outstanding txns)
//  err_clr_i        in  NumPorts                synchronous clear of error counter/flags
//  rd_cnt_o         out NumPorts x RdCntW       outstanding reads, RdCntW=$clog2(MaxRdTxns+1)
//  wr_cnt_o         out NumPorts x WrCntW       outstanding writes, WrCntW=$clog2(MaxWrTxns+1)
//  err_cnt_o        out NumPorts x ErrCntWidth  saturating count of errored R-last/B beats
//  underflow_o      out NumPorts                sticky: R-last/B seen with counter at 0
// BEHAVIOUR
//  Reset: all counters 0, FSM RUN, drain_ack_o 0, underflow_o 0, err_cnt_o 0.
//  Gating (combinational, zero latency): allow_rd = (state==RUN) && rd_cnt<MaxRdTxns;
//   ar_valid_o = ar_valid_i & allow_rd; ar_ready_o = ar_ready_i & allow_rd. AW likewise.
//   allow_* is registered-state only; never depends on ar_ready_i (no comb loop valid->ready).
//  AR handshake = ar_valid_o&ar_ready_i: rd_cnt+1. R handshake with r_last_i: rd_cnt-1.
//   Both same cycle: unchanged. AW handshake wr_cnt+1; B handshake wr_cnt-1; same rule.
//  Decrement at 0: counter held at 0, underflow_o set (sticky until err_clr_i).
//  Counter never exceeds Max* (gating guarantees it); at limit the AR accepted in the same cycle
//   as a retiring R-last is NOT allowed (limit evaluated on registered count).
//  Errors: each R-last or B handshake with resp in {SLVERR=2'b10,DECERR=2'b11} adds 1 to err_cnt;
//   R and B error same cycle adds 2; saturates at all-ones. err_clr_i wins over increment that cycle.
//  Per-port FSM: RUN -(drain_req_i)-> DRAIN -(rd_cnt==0&&wr_cnt==0)-> DRAINED
//   -(!drain_req_i)-> RUN. DRAIN with drain_req_i dropped -> RUN. drain_ack_o=(state==DRAINED), registered.
//   DRAIN and DRAINED block new AR/AW; a handshake already in flight at request cycle completes
//   (gate is from registered state, so request cycle itself still permits acceptance).
//  Ports are fully independent; no arbitration between ports.
//  Async reset mid-transfer clears all state; slave-side txns are assumed reset together.
// STRUCTURE
//  Shared package axi_txn_reg_pkg: state enum (RUN,DRAIN,DRAINED), RESP_ERR helper function.
//  Sub-module axi_txn_reg_port (one port: two counters, FSM, error counter); top is a generate loop.
// TESTING
//  1 MaxRdTxns=4, 6 back-to-back ARs with ar_ready_i=1, no R -> 4 accepted, ar_ready_o=0, rd_cnt=4.
//  2 rd_cnt=4, R-last retire -> rd_cnt=3 next cycle, next AR accepted cycle after; simultaneous AR+R-last at cnt=2 -> stays 2.
//  3 drain_req_i with rd_cnt=2,wr_cnt=1 -> AR/AW blocked, drain_ack_o rises 1 cycle after last B; drop req -> RUN.
//  4 3 R-last SLVERR + 1 B DECERR (one coincident) -> err_cnt=4; ErrCntWidth=2 saturates at 3; err_clr_i -> 0.
//  5 B with wr_cnt=0 -> wr_cnt stays 0, underflow_o=1 until err_clr_i.
//  6 rst_ni low mid-burst (cnt=3, DRAIN) -> all outputs reset values asynchronously; port1 unaffected by port0 traffic.

Source files
------------

// File: rtl/axi_txn_reg_pkg.sv
// Shared types for the per-port AXI transaction regulator.
// Drain FSM state encoding and the AXI error-response decode.
package axi_txn_reg_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DRAINED = 2'd2
   } reg_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // SLVERR and DECERR share the upper bit; OKAY/EXOKAY do not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp[1];
   endfunction

endpackage

// File: rtl/axi_txn_reg_port.sv
// One regulated master port: outstanding rd/wr counters, drain FSM, error counter.
// Latency: AR/AW gating is combinational from registered state; counters/flags update next cycle.
// Backpressure: deasserts both valid and ready of AR/AW when at limit or not RUN; R/B never gated.
module axi_txn_reg_port
   import axi_txn_reg_pkg::*;
#(
   parameter int unsigned MaxRdTxns   = 4,
   parameter int unsigned MaxWrTxns   = 4,
   parameter int unsigned ErrCntWidth = 16,
   parameter int unsigned RdCntW      = $clog2(MaxRdTxns + 1),
   parameter int unsigned WrCntW      = $clog2(MaxWrTxns + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   ar_valid_i,
   output logic                   ar_ready_o,
   output logic                   ar_valid_o,
   input  logic                   ar_ready_i,
   input  logic                   aw_valid_i,
   output logic                   aw_ready_o,
   output logic                   aw_valid_o,
   input  logic                   aw_ready_i,
   input  logic                   r_valid_i,
   input  logic                   r_ready_i,
   input  logic                   r_last_i,
   input  logic [1:0]             r_resp_i,
   input  logic                   b_valid_i,
   input  logic                   b_ready_i,
   input  logic [1:0]             b_resp_i,
   input  logic                   drain_req_i,
   output logic                   drain_ack_o,
   input  logic                   err_clr_i,
   output logic [RdCntW-1:0]      rd_cnt_o,
   output logic [WrCntW-1:0]      wr_cnt_o,
   output logic [ErrCntWidth-1:0] err_cnt_o,
   output logic                   underflow_o
);

   localparam logic [RdCntW-1:0] RD_MAX = RdCntW'(MaxRdTxns);
   localparam logic [WrCntW-1:0] WR_MAX = WrCntW'(MaxWrTxns);
   localparam logic [RdCntW-1:0] RD_ONE = RdCntW'(1);
   localparam logic [WrCntW-1:0] WR_ONE = WrCntW'(1);

   reg_state_e             state_q, state_d;
   logic [RdCntW-1:0]      rd_cnt_q, rd_cnt_d;
   logic [WrCntW-1:0]      wr_cnt_q, wr_cnt_d;
   logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
   logic [ErrCntWidth:0]   err_sum;
   logic [1:0]             err_inc;
   logic                   uf_q, uf_d;
   logic                   allow_rd, allow_wr;
   logic                   ar_hs, aw_hs, r_done, b_done;
   logic                   rd_uf, wr_uf;

   // Limit is taken on the registered count so a same-cycle retire cannot open the gate.
   assign allow_rd = (state_q == ST_RUN) && (rd_cnt_q < RD_MAX);
   assign allow_wr = (state_q == ST_RUN) && (wr_cnt_q < WR_MAX);

   assign ar_valid_o = ar_valid_i & allow_rd;
   assign ar_ready_o = ar_ready_i & allow_rd;
   assign aw_valid_o = aw_valid_i & allow_wr;
   assign aw_ready_o = aw_ready_i & allow_wr;

   assign ar_hs  = ar_valid_o & ar_ready_i;
   assign aw_hs  = aw_valid_o & aw_ready_i;
   assign r_done = r_valid_i & r_ready_i & r_last_i;
   assign b_done = b_valid_i & b_ready_i;

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      rd_uf    = 1'b0;
      if (ar_hs && !r_done) begin
         rd_cnt_d = rd_cnt_q + RD_ONE;
      end else if (!ar_hs && r_done) begin
         if (rd_cnt_q == '0) rd_uf = 1'b1;
         else                rd_cnt_d = rd_cnt_q - RD_ONE;
      end
   end

   always_comb begin
      wr_cnt_d = wr_cnt_q;
      wr_uf    = 1'b0;
      if (aw_hs && !b_done) begin
         wr_cnt_d = wr_cnt_q + WR_ONE;
      end else if (!aw_hs && b_done) begin
         if (wr_cnt_q == '0) wr_uf = 1'b1;
         else                wr_cnt_d = wr_cnt_q - WR_ONE;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (drain_req_i) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_req_i)                             state_d = ST_RUN;
            else if (rd_cnt_q == '0 && wr_cnt_q == '0)    state_d = ST_DRAINED;
         end
         ST_DRAINED: begin
            if (!drain_req_i) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Sum is one bit wider so a carry out signals saturation.
   always_comb begin
      err_inc   = {1'b0, r_done && resp_is_err(r_resp_i)} +
                  {1'b0, b_done && resp_is_err(b_resp_i)};
      err_sum   = {1'b0, err_cnt_q} + (ErrCntWidth + 1)'(err_inc);
      err_cnt_d = err_cnt_q;
      if (err_clr_i)                 err_cnt_d = '0;
      else if (err_sum[ErrCntWidth]) err_cnt_d = '1;
      else                           err_cnt_d = err_sum[ErrCntWidth-1:0];
      uf_d = err_clr_i ? 1'b0 : (uf_q | rd_uf | wr_uf);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_RUN;
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
         uf_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         err_cnt_q <= err_cnt_d;
         uf_q      <= uf_d;
      end
   end

   assign drain_ack_o = (state_q == ST_DRAINED);
   assign rd_cnt_o    = rd_cnt_q;
   assign wr_cnt_o    = wr_cnt_q;
   assign err_cnt_o   = err_cnt_q;
   assign underflow_o = uf_q;

endmodule

// File: rtl/axi_txn_regulator.sv
// Per-master AXI outstanding-transaction regulator with drain handshake and error counting.
// Latency: zero-cycle AR/AW gating; status outputs are registered (one cycle).
// Backpressure: per-port AR/AW valid+ready masked at limit or while draining; payload untouched.
module axi_txn_regulator
   import axi_txn_reg_pkg::*;
#(
   parameter  int unsigned NumPorts    = 2,
   parameter  int unsigned MaxRdTxns   = 4,
   parameter  int unsigned MaxWrTxns   = 4,
   parameter  int unsigned ErrCntWidth = 16,
   localparam int unsigned RdCntW      = $clog2(MaxRdTxns + 1),
   localparam int unsigned WrCntW      = $clog2(MaxWrTxns + 1)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NumPorts-1:0]             ar_valid_i,
   output logic [NumPorts-1:0]             ar_ready_o,
   output logic [NumPorts-1:0]             ar_valid_o,
   input  logic [NumPorts-1:0]             ar_ready_i,
   input  logic [NumPorts-1:0]             aw_valid_i,
   output logic [NumPorts-1:0]             aw_ready_o,
   output logic [NumPorts-1:0]             aw_valid_o,
   input  logic [NumPorts-1:0]             aw_ready_i,
   input  logic [NumPorts-1:0]             r_valid_i,
   input  logic [NumPorts-1:0]             r_ready_i,
   input  logic [NumPorts-1:0]             r_last_i,
   input  logic [2*NumPorts-1:0]           r_resp_i,
   input  logic [NumPorts-1:0]             b_valid_i,
   input  logic [NumPorts-1:0]             b_ready_i,
   input  logic [2*NumPorts-1:0]           b_resp_i,
   input  logic [NumPorts-1:0]             drain_req_i,
   output logic [NumPorts-1:0]             drain_ack_o,
   input  logic [NumPorts-1:0]             err_clr_i,
   output logic [NumPorts*RdCntW-1:0]      rd_cnt_o,
   output logic [NumPorts*WrCntW-1:0]      wr_cnt_o,
   output logic [NumPorts*ErrCntWidth-1:0] err_cnt_o,
   output logic [NumPorts-1:0]             underflow_o
);

   // Ports are fully independent; no shared state or arbitration.
   for (genvar p = 0; p < NumPorts; p++) begin : g_port
      axi_txn_reg_port #(
         .MaxRdTxns   (MaxRdTxns),
         .MaxWrTxns   (MaxWrTxns),
         .ErrCntWidth (ErrCntWidth),
         .RdCntW      (RdCntW),
         .WrCntW      (WrCntW)
      ) u_port (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .ar_valid_i  (ar_valid_i[p]),
         .ar_ready_o  (ar_ready_o[p]),
         .ar_valid_o  (ar_valid_o[p]),
         .ar_ready_i  (ar_ready_i[p]),
         .aw_valid_i  (aw_valid_i[p]),
         .aw_ready_o  (aw_ready_o[p]),
         .aw_valid_o  (aw_valid_o[p]),
         .aw_ready_i  (aw_ready_i[p]),
         .r_valid_i   (r_valid_i[p]),
         .r_ready_i   (r_ready_i[p]),
         .r_last_i    (r_last_i[p]),
         .r_resp_i    (r_resp_i[2*p +: 2]),
         .b_valid_i   (b_valid_i[p]),
         .b_ready_i   (b_ready_i[p]),
         .b_resp_i    (b_resp_i[2*p +: 2]),
         .drain_req_i (drain_req_i[p]),
         .drain_ack_o (drain_ack_o[p]),
         .err_clr_i   (err_clr_i[p]),
         .rd_cnt_o    (rd_cnt_o[p*RdCntW +: RdCntW]),
         .wr_cnt_o    (wr_cnt_o[p*WrCntW +: WrCntW]),
         .err_cnt_o   (err_cnt_o[p*ErrCntWidth +: ErrCntWidth]),
         .underflow_o (underflow_o[p])
      );
   end

endmodule

// File: tb/tb_axi_txn_regulator.sv
// Bench for axi_txn_regulator: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a port-level behavioural model.
module tb_axi_txn_regulator;

   localparam int NP = 2;
   localparam int MR = 4;
   localparam int MW = 3;
   localparam int EW = 3;
   localparam int RW = $clog2(MR + 1);
   localparam int WW = $clog2(MW + 1);
   localparam int ERR_MAX = (1 << EW) - 1;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [NP-1:0]    ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i;
   logic [NP-1:0]    aw_valid_i, aw_ready_o, aw_valid_o, aw_ready_i;
   logic [NP-1:0]    r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i;
   logic [2*NP-1:0]  r_resp_i, b_resp_i;
   logic [NP-1:0]    drain_req_i, drain_ack_o, err_clr_i, underflow_o;
   logic [NP*RW-1:0] rd_cnt_o;
   logic [NP*WW-1:0] wr_cnt_o;
   logic [NP*EW-1:0] err_cnt_o;

   axi_txn_regulator #(
      .NumPorts(NP), .MaxRdTxns(MR), .MaxWrTxns(MW), .ErrCntWidth(EW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
      .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
      .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i), .r_resp_i(r_resp_i),
      .b_valid_i(b_valid_i), .b_ready_i(b_ready_i), .b_resp_i(b_resp_i),
      .drain_req_i(drain_req_i), .drain_ack_o(drain_ack_o), .err_clr_i(err_clr_i),
      .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o), .err_cnt_o(err_cnt_o), .underflow_o(underflow_o)
   );

   // Model: 0 = running, 1 = draining, 2 = drained
   int m_rd[NP], m_wr[NP], m_mode[NP], m_err[NP];
   bit m_uf[NP];
   int n_cmp = 0;
   int n_bad = 0;
   int acc0  = 0;

   task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s port%0d at %0t: got %0d expected %0d", nm, p, $time, act, exp);
      end
   endtask

   task automatic clear_inputs();
      ar_valid_i = '0; ar_ready_i = '0; aw_valid_i = '0; aw_ready_i = '0;
      r_valid_i = '0; r_ready_i = '0; r_last_i = '0; r_resp_i = '0;
      b_valid_i = '0; b_ready_i = '0; b_resp_i = '0;
      drain_req_i = '0; err_clr_i = '0;
   endtask

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_rd[p] = 0; m_wr[p] = 0; m_mode[p] = 0; m_err[p] = 0; m_uf[p] = 1'b0;
      end
   endtask

   task automatic check_all();
      bit open_rd, open_wr;
      for (int p = 0; p < NP; p++) begin
         open_rd = (m_mode[p] == 0) && (m_rd[p] < MR);
         open_wr = (m_mode[p] == 0) && (m_wr[p] < MW);
         chk("ar_valid_o", p, 32'(ar_valid_o[p]), 32'(ar_valid_i[p] & open_rd));
         chk("ar_ready_o", p, 32'(ar_ready_o[p]), 32'(ar_ready_i[p] & open_rd));
         chk("aw_valid_o", p, 32'(aw_valid_o[p]), 32'(aw_valid_i[p] & open_wr));
         chk("aw_ready_o", p, 32'(aw_ready_o[p]), 32'(aw_ready_i[p] & open_wr));
         chk("rd_cnt", p, 32'(rd_cnt_o[p*RW +: RW]), 32'(m_rd[p]));
         chk("wr_cnt", p, 32'(wr_cnt_o[p*WW +: WW]), 32'(m_wr[p]));
         chk("err_cnt", p, 32'(err_cnt_o[p*EW +: EW]), 32'(m_err[p]));
         chk("underflow", p, 32'(underflow_o[p]), 32'(m_uf[p]));
         chk("drain_ack", p, 32'(drain_ack_o[p]), 32'(m_mode[p] == 2));
      end
   endtask

   task automatic model_advance();
      bit open_rd, open_wr, ar_ok, aw_ok, r_end, b_end, uf_now;
      int net, errs;
      for (int p = 0; p < NP; p++) begin
         open_rd = (m_mode[p] == 0) && (m_rd[p] < MR);
         open_wr = (m_mode[p] == 0) && (m_wr[p] < MW);
         ar_ok   = ar_valid_i[p] && ar_ready_i[p] && open_rd;
         aw_ok   = aw_valid_i[p] && aw_ready_i[p] && open_wr;
         r_end   = r_valid_i[p] && r_ready_i[p] && r_last_i[p];
         b_end   = b_valid_i[p] && b_ready_i[p];
         uf_now  = 1'b0;
         case (m_mode[p])
            0: if (drain_req_i[p]) m_mode[p] = 1;
            1: if (!drain_req_i[p]) m_mode[p] = 0;
               else if (m_rd[p] == 0 && m_wr[p] == 0) m_mode[p] = 2;
            default: if (!drain_req_i[p]) m_mode[p] = 0;
         endcase
         net = int'(ar_ok) - int'(r_end);
         if (m_rd[p] + net < 0) uf_now = 1'b1; else m_rd[p] += net;
         net = int'(aw_ok) - int'(b_end);
         if (m_wr[p] + net < 0) uf_now = 1'b1; else m_wr[p] += net;
         errs = 0;
         if (r_end && r_resp_i[2*p +: 2] >= 2) errs++;
         if (b_end && b_resp_i[2*p +: 2] >= 2) errs++;
         if (err_clr_i[p]) begin
            m_err[p] = 0;
            m_uf[p]  = 1'b0;
         end else begin
            m_err[p] = (m_err[p] + errs > ERR_MAX) ? ERR_MAX : m_err[p] + errs;
            m_uf[p]  = m_uf[p] | uf_now;
         end
      end
   endtask

   // Inputs are applied at the falling edge; compare 1ns later, then advance the model.
   task automatic step();
      #1;
      check_all();
      if (ar_valid_o[0] && ar_ready_i[0]) acc0++;
      model_advance();
      @(negedge clk_i);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rlast0(input logic [1:0] resp);
      r_valid_i[0] = 1'b1; r_ready_i[0] = 1'b1; r_last_i[0] = 1'b1; r_resp_i[1:0] = resp;
   endtask

   task automatic bresp0(input logic [1:0] resp);
      b_valid_i[0] = 1'b1; b_ready_i[0] = 1'b1; b_resp_i[1:0] = resp;
   endtask

   bit drq[NP];

   initial begin
      clear_inputs();
      model_reset();
      repeat (2) @(negedge clk_i);
      chk("reset_rd_cnt", 0, 32'(rd_cnt_o), 32'd0);
      chk("reset_err_cnt", 0, 32'(err_cnt_o), 32'd0);
      chk("reset_ack_uf", 0, 32'({drain_ack_o, underflow_o}), 32'd0);
      rst_ni = 1'b1;
      step();

      // Limit: 6 back-to-back ARs, only MR accepted
      ar_valid_i[0] = 1'b1; ar_ready_i[0] = 1'b1;
      acc0 = 0;
      steps(6);
      #1;
      chk("t1_rd_cnt", 0, 32'(rd_cnt_o[RW-1:0]), 32'd4);
      chk("t1_accepted", 0, 32'(acc0), 32'd4);
      chk("t1_ar_ready_o", 0, 32'(ar_ready_o[0]), 32'd0);

      // Retire at limit: no acceptance in the retire cycle, next cycle reopens
      rlast0(2'b00);
      step();
      r_valid_i[0] = 1'b0;
      #1;
      chk("t2_rd_after_retire", 0, 32'(rd_cnt_o[RW-1:0]), 32'd3);
      chk("t2_ar_ready_reopen", 0, 32'(ar_ready_o[0]), 32'd1);
      step();
      ar_valid_i[0] = 1'b0;
      rlast0(2'b00);
      steps(2);
      ar_valid_i[0] = 1'b1;
      step();
      #1;
      chk("t2_simul_ar_r", 0, 32'(rd_cnt_o[RW-1:0]), 32'd2);
      clear_inputs();

      // Drain with rd=2, wr=1
      aw_valid_i[0] = 1'b1; aw_ready_i[0] = 1'b1;
      step();
      clear_inputs();
      drain_req_i[0] = 1'b1;
      step();
      ar_valid_i[0] = 1'b1; ar_ready_i[0] = 1'b1; aw_valid_i[0] = 1'b1; aw_ready_i[0] = 1'b1;
      #1;
      chk("t3_ar_blocked", 0, 32'(ar_valid_o[0]), 32'd0);
      chk("t3_aw_blocked", 0, 32'(aw_ready_o[0]), 32'd0);
      step();
      ar_valid_i[0] = 1'b0; aw_valid_i[0] = 1'b0;
      rlast0(2'b00);
      steps(2);
      r_valid_i[0] = 1'b0;
      bresp0(2'b00);
      step();
      b_valid_i[0] = 1'b0;
      #1;
      chk("t3_ack_not_yet", 0, 32'(drain_ack_o[0]), 32'd0);
      step();
      chk("t3_ack", 0, 32'(drain_ack_o[0]), 32'd1);
      drain_req_i[0] = 1'b0;
      step();
      #1;
      chk("t3_ack_drop", 0, 32'(drain_ack_o[0]), 32'd0);
      chk("t3_run_again", 0, 32'(ar_ready_o[0]), 32'd1);
      clear_inputs();

      // Errors: 3 R-last SLVERR + 1 B DECERR, last two coincident
      ar_valid_i[0] = 1'b1; ar_ready_i[0] = 1'b1; aw_valid_i[0] = 1'b1; aw_ready_i[0] = 1'b1;
      step();
      aw_valid_i[0] = 1'b0;
      steps(2);
      clear_inputs();
      rlast0(2'b10);
      steps(2);
      bresp0(2'b11);
      step();
      clear_inputs();
      #1;
      chk("t4_err_cnt", 0, 32'(err_cnt_o[EW-1:0]), 32'd4);
      rlast0(2'b11); bresp0(2'b10);
      steps(2);
      clear_inputs();
      #1;
      chk("t4_err_sat", 0, 32'(err_cnt_o[EW-1:0]), 32'(ERR_MAX));
      rlast0(2'b10); err_clr_i[0] = 1'b1;
      step();
      clear_inputs();
      #1;
      chk("t4_err_clr", 0, 32'(err_cnt_o[EW-1:0]), 32'd0);

      // Underflow on B with wr=0
      bresp0(2'b00);
      step();
      clear_inputs();
      #1;
      chk("t5_wr_held", 0, 32'(wr_cnt_o[WW-1:0]), 32'd0);
      chk("t5_uf_set", 0, 32'(underflow_o[0]), 32'd1);
      step();
      chk("t5_uf_sticky", 0, 32'(underflow_o[0]), 32'd1);
      err_clr_i[0] = 1'b1;
      step();
      clear_inputs();
      #1;
      chk("t5_uf_clr", 0, 32'(underflow_o[0]), 32'd0);

      // Async reset mid-burst while draining; port1 unaffected by port0 traffic
      ar_valid_i[0] = 1'b1; ar_ready_i[0] = 1'b1;
      steps(3);
      ar_valid_i[0] = 1'b0;
      drain_req_i[0] = 1'b1;
      step();
      #1;
      chk("t6_rd_before", 0, 32'(rd_cnt_o[RW-1:0]), 32'd3);
      chk("t6_port1_idle", 1, 32'(rd_cnt_o[2*RW-1:RW]), 32'd0);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t6_rst_rd", 0, 32'(rd_cnt_o), 32'd0);
      chk("t6_rst_ack", 0, 32'(drain_ack_o), 32'd0);
      model_reset();
      @(negedge clk_i);
      clear_inputs();
      rst_ni = 1'b1;
      step();

      // Randomized traffic in phases with varying accept/retire pressure
      for (int p = 0; p < NP; p++) drq[p] = 1'b0;
      for (int ph = 0; ph < 8; ph++) begin
         int pa, pr;
         pa = (ph % 2 == 1) ? 80 : 40;
         pr = (ph % 3 == 0) ? 15 : 45;
         for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NP; p++) begin
               if ($urandom_range(99) < 3) drq[p] = !drq[p];
               drain_req_i[p] = drq[p];
               ar_valid_i[p]  = $urandom_range(99) < pa;
               ar_ready_i[p]  = $urandom_range(99) < 70;
               aw_valid_i[p]  = $urandom_range(99) < pa;
               aw_ready_i[p]  = $urandom_range(99) < 70;
               r_valid_i[p]   = $urandom_range(99) < pr;
               r_ready_i[p]   = $urandom_range(99) < 80;
               r_last_i[p]    = $urandom_range(99) < 60;
               b_valid_i[p]   = $urandom_range(99) < pr;
               b_ready_i[p]   = $urandom_range(99) < 80;
               r_resp_i[2*p +: 2] = 2'($urandom_range(3));
               b_resp_i[2*p +: 2] = 2'($urandom_range(3));
               err_clr_i[p]   = $urandom_range(99) < 2;
            end
            step();
         end
         if (ph == 4) begin
            #2;
            rst_ni = 1'b0;
            #1;
            chk("rnd_rst_cnts", 0, 32'({rd_cnt_o, wr_cnt_o}), 32'd0);
            chk("rnd_rst_err", 0, 32'({err_cnt_o, underflow_o, drain_ack_o}), 32'd0);
            model_reset();
            @(negedge clk_i);
            rst_ni = 1'b1;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
